// File: rtl/vga_scanout_pkg.sv
// Shared timing constants, pipeline depth and pixel/control types for vga_scanout.
package vga_scanout_pkg;

    localparam int unsigned VGA_H_VIS    = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_VIS    = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam int unsigned VGA_H_TOTAL  = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL  = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int unsigned VGA_HS_START = VGA_H_VIS + VGA_H_FP;
    localparam int unsigned VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
    localparam int unsigned VGA_VS_START = VGA_V_VIS + VGA_V_FP;
    localparam int unsigned VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

    localparam int unsigned VGA_FB_W     = 160;
    localparam int unsigned SCALE_LOG2   = 2;
    localparam int unsigned RD_LAT       = 2;
    localparam int unsigned PIPE         = RD_LAT + 2;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic vblank;
        logic fstart;
    } ctl_t;

endpackage

// File: rtl/vga_scanout_timing_gen.sv
// Horizontal/vertical raster counters with raw (unaligned) sync, active and frame flags.
module vga_timing_gen
    import vga_scanout_pkg::*;
#(
    parameter int unsigned H_VIS  = VGA_H_VIS,
    parameter int unsigned H_FP   = VGA_H_FP,
    parameter int unsigned H_SYNC = VGA_H_SYNC,
    parameter int unsigned H_BP   = VGA_H_BP,
    parameter int unsigned V_VIS  = VGA_V_VIS,
    parameter int unsigned V_FP   = VGA_V_FP,
    parameter int unsigned V_SYNC = VGA_V_SYNC,
    parameter int unsigned V_BP   = VGA_V_BP
) (
    input  logic clock,
    input  logic reset_n,
    output logic line_end,
    output logic frame_end,
    output logic v_vis,
    output logic active,
    output logic hsync,
    output logic vsync,
    output logic fstart
);

    localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS10  = 10'(H_VIS);
    localparam logic [9:0] V_VIS10  = 10'(V_VIS);
    localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC - 1);

    logic [9:0] h;
    logic [9:0] v;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            h <= '0;
            v <= '0;
        end else if (line_end) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    always_comb begin
        line_end  = (h == H_LAST);
        frame_end = line_end && (v == V_LAST);
        v_vis     = (v < V_VIS10);
        active    = (h < H_VIS10) && v_vis;
        hsync     = (h >= HS_START) && (h <= HS_END);
        vsync     = (v >= VS_START) && (v <= VS_END);
        fstart    = (h == '0) && (v == '0);
    end

endmodule

// File: rtl/vga_scanout.sv
// 640x480@60 scanout of a 160x120 RGB444 framebuffer with 4x4 replication.
// Optional test pattern input enabled by defining VGA_SCANOUT_TEST_PATTERN_EN.
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int unsigned H_VIS  = VGA_H_VIS,
    parameter int unsigned H_FP   = VGA_H_FP,
    parameter int unsigned H_SYNC = VGA_H_SYNC,
    parameter int unsigned H_BP   = VGA_H_BP,
    parameter int unsigned V_VIS  = VGA_V_VIS,
    parameter int unsigned V_FP   = VGA_V_FP,
    parameter int unsigned V_SYNC = VGA_V_SYNC,
    parameter int unsigned V_BP   = VGA_V_BP,
    parameter int unsigned FB_W   = VGA_FB_W
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] base_addr,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    output logic [15:0] address_vga,
    input  logic [15:0] q_vga,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        vblank,
    output logic        frame_start
);

    localparam logic [15:0] FB_STEP = 16'(FB_W);

    logic line_end, frame_end, v_vis, active, hsync, vsync, fstart;

    vga_timing_gen #(
        .H_VIS (H_VIS),  .H_FP (H_FP),  .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_VIS (V_VIS),  .V_FP (V_FP),  .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clock     (clock),
        .reset_n   (reset_n),
        .line_end  (line_end),
        .frame_end (frame_end),
        .v_vis     (v_vis),
        .active    (active),
        .hsync     (hsync),
        .vsync     (vsync),
        .fstart    (fstart)
    );

    logic [SCALE_LOG2-1:0] hsub, vsub;
    logic [15:0]           col, row_base, frame_base;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    logic [3:0]            row_idx;
`endif

    // row_base steps by FB_W every 4th line, so no multiplier sits in the address path
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hsub        <= '0;
            vsub        <= '0;
            col         <= '0;
            row_base    <= '0;
            frame_base  <= '0;
            address_vga <= '0;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
            row_idx     <= '0;
`endif
        end else begin
            if (line_end) begin
                hsub <= '0;
                col  <= '0;
            end else if (active) begin
                hsub <= hsub + 1'b1;
                if (hsub == '1) col <= col + 1'b1;
            end
            if (frame_end) begin
                vsub       <= '0;
                row_base   <= '0;
                frame_base <= base_addr;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
                row_idx    <= '0;
`endif
            end else if (line_end && v_vis) begin
                vsub <= vsub + 1'b1;
                if (vsub == '1) begin
                    row_base <= row_base + FB_STEP;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
                    row_idx  <= row_idx + 1'b1;
`endif
                end
            end
            if (active) address_vga <= frame_base + row_base + col;
        end
    end

    ctl_t ctl_raw;
    ctl_t ctl_q [PIPE];

    always_comb begin
        ctl_raw        = '0;
        ctl_raw.active = active;
        ctl_raw.hsync  = hsync;
        ctl_raw.vsync  = vsync;
        ctl_raw.vblank = !v_vis;
        ctl_raw.fstart = fstart;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < PIPE; i++) ctl_q[i] <= '0;
        end else begin
            ctl_q[0] <= ctl_raw;
            for (int unsigned i = 1; i < PIPE; i++) ctl_q[i] <= ctl_q[i-1];
        end
    end

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    rgb444_t         pat_q [PIPE-1];
    logic [PIPE-2:0] tm_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < PIPE - 1; i++) pat_q[i] <= '0;
            tm_q <= '0;
        end else begin
            pat_q[0] <= {col[3:0], row_idx, col[7:4]};
            for (int unsigned i = 1; i < PIPE - 1; i++) pat_q[i] <= pat_q[i-1];
            tm_q <= {tm_q[PIPE-3:0], test_mode};
        end
    end
`endif

    rgb444_t pix, rgb_q;
    logic    unused_q_bits;

    assign unused_q_bits = ^q_vga[15:12];

    always_comb begin
        pix = rgb444_t'(q_vga[11:0]);
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        if (tm_q[PIPE-2]) pix = pat_q[PIPE-2];
`endif
    end

    // Stage PIPE-2 lines up with q_vga for the same raster position
    always_ff @(posedge clock) begin
        if (!reset_n) rgb_q <= '0;
        else          rgb_q <= ctl_q[PIPE-2].active ? pix : '0;
    end

    assign VGA_R       = rgb_q.r;
    assign VGA_G       = rgb_q.g;
    assign VGA_B       = rgb_q.b;
    assign VGA_HS      = ~ctl_q[PIPE-1].hsync;
    assign VGA_VS      = ~ctl_q[PIPE-1].vsync;
    assign vblank      = ctl_q[PIPE-1].vblank;
    assign frame_start = ctl_q[PIPE-1].fstart;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench: full 640x480 instance for line timing, reduced-raster instance for frame-level behaviour.
module tb_vga_scanout;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_f, rst_s;
    logic [15:0] base_f, base_s, addr_f, addr_s, q_f, q_s, ram_f1, ram_s1;
    logic [3:0]  r_f, g_f, b_f, r_s, g_s, b_s;
    logic        hs_f, vs_f, vb_f, fs_f, hs_s, vs_s, vb_s, fs_s;
    logic        tm_f = 1'b0;
    logic        tm_s = 1'b0;
    int          cyc_f = 0;
    int          cyc_s = 0;
    int          n_vec = 0;
    int          n_err = 0;

    wire [11:0] rgb_f = {r_f, g_f, b_f};
    wire [11:0] rgb_s = {r_s, g_s, b_s};

    vga_scanout dut (
        .clock       (clock),
        .reset_n     (rst_f),
        .base_addr   (base_f),
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        .test_mode   (tm_f),
`endif
        .address_vga (addr_f),
        .q_vga       (q_f),
        .VGA_R       (r_f),
        .VGA_G       (g_f),
        .VGA_B       (b_f),
        .VGA_HS      (hs_f),
        .VGA_VS      (vs_f),
        .vblank      (vb_f),
        .frame_start (fs_f)
    );

    // Reduced raster: 48 clocks/line (HS at h 36..43), 22 lines/frame (VS at v 18..19), 8 words/row
    vga_scanout #(
        .H_VIS (32), .H_FP (4), .H_SYNC (8), .H_BP (4),
        .V_VIS (16), .V_FP (2), .V_SYNC (2), .V_BP (2),
        .FB_W  (8)
    ) dut_s (
        .clock       (clock),
        .reset_n     (rst_s),
        .base_addr   (base_s),
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        .test_mode   (tm_s),
`endif
        .address_vga (addr_s),
        .q_vga       (q_s),
        .VGA_R       (r_s),
        .VGA_G       (g_s),
        .VGA_B       (b_s),
        .VGA_HS      (hs_s),
        .VGA_VS      (vs_s),
        .vblank      (vb_s),
        .frame_start (fs_s)
    );

    // RAM port-b models, two-clock latency, data = address
    always @(posedge clock) begin
        ram_f1 <= addr_f;
        q_f    <= ram_f1;
        ram_s1 <= addr_s;
        q_s    <= ram_s1;
    end

    always @(posedge clock) begin
        cyc_f <= rst_f ? cyc_f + 1 : 0;
        cyc_s <= rst_s ? cyc_s + 1 : 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_f(input int n);
        while (cyc_f < n) @(negedge clock);
    endtask

    task automatic wait_s(input int n);
        while (cyc_s < n) @(negedge clock);
    endtask

    // Frame-level monitor on the reduced instance over one full frame window
    bit mon_done = 1'b0;
    int fs_cnt = 0, fs_first = 0, fs_last = 0, vs_lo = 0, vb_hi = 0;
    always @(negedge clock) begin
        if (!mon_done && rst_s && cyc_s >= 1060 && cyc_s <= 2200) begin
            if (fs_s) begin
                fs_cnt++;
                if (fs_first == 0) fs_first = cyc_s;
                fs_last = cyc_s;
            end
            if (!vs_s) vs_lo++;
            if (vb_s)  vb_hi++;
        end
    end

    task automatic run_full();
        int hs_first = 0;
        int hs_cnt   = 0;
        wait_f(3);    check("fs_f_c3", fs_f, 1'b0);
        wait_f(4);    check("fs_f_c4", fs_f, 1'b1);
        wait_f(5);    check("fs_f_c5", fs_f, 1'b0);
        wait_f(8);    check("rgb_f_px4", rgb_f, 12'h001);
        wait_f(12);   check("rgb_f_px8", rgb_f, 12'h002);
        wait_f(643);  check("rgb_f_px639", rgb_f, 12'h09F);
        wait_f(644);  check("rgb_f_px640", rgb_f, 12'h000);
        for (int c = 645; c <= 900; c++) begin
            wait_f(c);
            if (!hs_f) begin
                hs_cnt++;
                if (hs_first == 0) hs_first = c;
            end
        end
        check("hs_f_fall", hs_first, 660);
        check("hs_f_width", hs_cnt, 96);
        wait_f(2412); check("rgb_f_l3px8", rgb_f, 12'h002);
        wait_f(3204); check("rgb_f_l4px0", rgb_f, 12'h0A0);
                      check("vb_f_l4", vb_f, 1'b0);
                      check("vs_f_l4", vs_f, 1'b1);
        wait_f(3212); check("rgb_f_l4px8", rgb_f, 12'h0A2);
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        wait_f(3220); tm_f = 1'b1;
        wait_f(3268); check("tpat_f_l4px64", rgb_f, 12'h011);
`endif
    endtask

    task automatic run_small();
        wait_s(1057); check("addr_s_f1px0", addr_s, 16'h1000);
        wait_s(1060); check("fs_s_f1", fs_s, 1'b1);
        wait_s(1061); check("addr_s_f1px4", addr_s, 16'h1001);
        wait_s(1249); check("addr_s_l4px0", addr_s, 16'h1008);
        wait_s(1252); check("rgb_s_l4px0", rgb_s, 12'h008);
        wait_s(1440); base_s = 16'h6000;
        wait_s(1633); check("addr_s_l12_oldbase", addr_s, 16'h1018);
        wait_s(1808); check("addr_s_lastpx", addr_s, 16'h101F);
        wait_s(1824); check("addr_s_hold", addr_s, 16'h101F);
        wait_s(2113); check("addr_s_f2px0", addr_s, 16'h6000);
        wait_s(2201);
        mon_done = 1'b1;
        check("fs_s_count", fs_cnt, 2);
        check("fs_s_period", fs_last - fs_first, 1056);
        check("vs_s_low", vs_lo, 96);
        check("vb_s_high", vb_hi, 288);
        // Mid-line reset at (h=20, v=5) of frame 2
        wait_s(2372); check("rgb_s_prerst", rgb_s, 12'h00C);
        rst_s  = 1'b0;
        base_s = 16'hFFF0;
        @(negedge clock);
        check("rst_s_rgb", rgb_s, 12'h000);
        check("rst_s_addr", addr_s, 16'h0000);
        check("rst_s_hs", hs_s, 1'b1);
        check("rst_s_vs", vs_s, 1'b1);
        check("rst_s_fs", fs_s, 1'b0);
        rst_s = 1'b1;
        wait_s(3);    check("fs_s_rel3", fs_s, 1'b0);
        wait_s(4);    check("fs_s_rel4", fs_s, 1'b1);
        wait_s(5);    check("addr_s_rel_px4", addr_s, 16'h0001);
        wait_s(1277); check("addr_s_wrap_ffff", addr_s, 16'hFFFF);
        wait_s(1441); check("addr_s_wrap_0000", addr_s, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_f  = 1'b0;
        rst_s  = 1'b0;
        base_f = 16'h0000;
        base_s = 16'h1000;
        repeat (5) @(negedge clock);
        check("rst_f_hs", hs_f, 1'b1);
        check("rst_f_vs", vs_f, 1'b1);
        check("rst_f_rgb", rgb_f, 12'h000);
        check("rst_f_vb", vb_f, 1'b0);
        check("rst_f_fs", fs_f, 1'b0);
        check("rst_f_addr", addr_f, 16'h0000);
        check("rst_s_init_hs", hs_s, 1'b1);
        check("rst_s_init_rgb", rgb_s, 12'h000);
        rst_f = 1'b1;
        rst_s = 1'b1;
        fork
            run_full();
            run_small();
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
